alu_exec: RTL and testbench
===========================

# alu_exec

Execution-stage ALU that consumes the 4-bit ALU control code produced by the ALU control decoder and performs the operation on two 32-bit operands. It sits between the decoder/register-read stage and write-back. Operands and results move through valid/ready handshakes. Single-cycle operations complete in one cycle; MUL runs as an iterative shift-add sequence unless the fast multiplier is compiled in.

## Interface
Parameters:
- WIDTH, 32, operand and result width; only 32 is supported.
- MUL_CYCLES, 32, number of iterations for the iterative multiplier; must equal WIDTH.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- valid_i  in  1  request is present on ALUCtl_i, data1_i and data2_i.
- ready_o  out  1  block accepts a request this cycle.
- ALUCtl_i  in  4  ALU control code.
- data1_i  in  32  operand rs1.
- data2_i  in  32  operand rs2 or immediate.
- valid_o  out  1  result is valid.
- ready_i  in  1  downstream accepts the result.
- data_o  out  32  result.
- zero_o  out  1  set when data_o == 0; meaningful only while valid_o = 1.

## Operation
- The control codes are defined in Const.v: AND=4'b0000, XOR=4'b0001, SLL=4'b0010, ADD=4'b0011, SUB=4'b0100, MUL=4'b0101, SRA=4'b0110.
- Operation results:
  - AND: data1 & data2
  - XOR: data1 ^ data2
  - SLL: data1 << data2[4:0]
  - ADD: data1 + data2, mod 2^32
  - SUB: data1 - data2, mod 2^32
  - SRA: $signed(data1) >>> data2[4:0]
  - MUL: low 32 bits of data1 * data2; the low 32 bits are the same for signed and unsigned operands.
- Any other code completes as a single-cycle operation with result 0.
- State machine:
  - IDLE: ready_o = 1. On an accept (valid_i & ready_o), a non-MUL request registers its result and moves to DONE. A MUL request loads the accumulator with 0, the multiplicand with data1, the multiplier with data2 and the counter with 0, then moves to BUSY.
  - BUSY: ready_o = 0. Each cycle: if multiplier[0] = 1, acc += mcand. Then mcand <<= 1, mplier >>= 1 and cnt++. After the MUL_CYCLES-th iteration, move to DONE with data_o = acc.
  - DONE: valid_o = 1 and data_o / zero_o are held stable. If ready_i = 0, stay. If ready_i = 1 and there is no new accept, go to IDLE.
- Simultaneous events:
  - ready_o = IDLE | (DONE & ready_i).
  - In DONE with ready_i = 1 and valid_i = 1, the result drains and the new request is accepted in the same cycle. The next state is DONE (new non-MUL result) or BUSY (new MUL).
- Operands are captured at accept. Input changes after the accept have no effect.

## Timing
- Reset values: state IDLE, ready_o = 1, valid_o = 0, data_o = 0, zero_o = 1. The counter and datapath registers reset to 0.
- Non-MUL latency: valid_o rises at the edge following the accept (1 cycle). With ready_i held high, throughput is one result per cycle.
- Iterative MUL latency: valid_o rises MUL_CYCLES + 1 = 33 edges after the accept. Back-to-back MULs complete one every 33 cycles.
- Reset asserted mid-operation (BUSY or DONE) aborts the operation immediately and asynchronously. All outputs return to their reset values and the partial product is discarded.
- valid_o never depends combinationally on ready_i. ready_o depends combinationally on ready_i only in DONE.

## Configuration
- ALU_MUL_FAST_EN defined:
  - MUL is handled like every other operation: data_o = data1 * data2 (low 32 bits) is registered with 1-cycle latency.
  - The BUSY state and the iterative datapath are not compiled.
- ALU_MUL_FAST_EN undefined: MUL uses the 32-iteration shift-add sequence above.
- Everything other than MUL latency is identical in both builds.

## Structure
- The ALU_CTL_* codes and the state encodings (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) live in Const.v, shared with the ALU control decoder.
- Sub-module alu_mul_iter holds the iterative multiplier:
  - Inputs: start pulse and operands.
  - Outputs: done pulse and product.
  - Owns acc, mcand, mplier and cnt.
  - Instantiated only when ALU_MUL_FAST_EN is undefined.
- The top level holds the FSM, the handshake and the single-cycle operation mux.

## Test plan
- ADD 32'hFFFF_FFFF + 32'h1, ready_i = 1 -> one cycle later valid_o = 1, data_o = 0, zero_o = 1.
- SRA data1 = 32'h8000_0000, data2 = 32'd4 -> data_o = 32'hF800_0000. SLL of 32'h1 by data2 = 32'h21 -> shift amount is 1, data_o = 32'h2.
- MUL 32'd7 * 32'hFFFF_FFFD, iterative build -> valid_o rises 33 cycles after the accept, data_o = 32'hFFFF_FFEB. In the fast build, the same result appears after 1 cycle.
- Back-pressure: SUB 5 - 3 completes with ready_i = 0 for 4 cycles -> valid_o stays 1, data_o stays 32'd2, ready_o = 0. When ready_i rises with a new XOR request on the inputs, the drain and accept happen in the same cycle.
- Reset is pulled low at iteration 10 of a MUL -> outputs immediately return to reset values. After release, ADD 1 + 1 returns 32'd2 with 1-cycle latency.
- Undefined code 4'b1111 with data1 = 32'h1234 -> data_o = 0, zero_o = 1, 1-cycle latency.

Source files
------------

// File: rtl/alu_exec_pkg.sv
// -----------------------------------------------------------------------------
// alu_exec_pkg
//
// Purpose : Shared definitions for the execution-stage ALU. This package holds
//           the ALU control codes and the FSM state encodings. The ALU control
//           decoder uses the same values. It also holds the helper function
//           that evaluates every single-cycle operation.
//
// Contents:
//   ALU_W          - datapath width (only 32 is supported)
//   alu_ctl_e      - 4-bit ALU control codes
//   alu_state_e    - execution FSM state encodings
//   alu_single_op  - combinational result of every non-MUL operation
// -----------------------------------------------------------------------------
package alu_exec_pkg;

   localparam int ALU_W = 32;

   typedef enum logic [3:0] {
      ALU_CTL_AND = 4'b0000,
      ALU_CTL_XOR = 4'b0001,
      ALU_CTL_SLL = 4'b0010,
      ALU_CTL_ADD = 4'b0011,
      ALU_CTL_SUB = 4'b0100,
      ALU_CTL_MUL = 4'b0101,
      ALU_CTL_SRA = 4'b0110
   } alu_ctl_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } alu_state_e;

   // Single-cycle operations. MUL and every unassigned code return 0 here.
   // The top level substitutes the product for MUL in the fast-multiplier
   // build.
   function automatic logic [ALU_W-1:0] alu_single_op(
      input logic [3:0]       ctl,
      input logic [ALU_W-1:0] a,
      input logic [ALU_W-1:0] b
   );
      logic [ALU_W-1:0] res;
      res = '0;
      case (ctl)
         ALU_CTL_AND: res = a & b;
         ALU_CTL_XOR: res = a ^ b;
         ALU_CTL_SLL: res = a << b[4:0];
         ALU_CTL_ADD: res = a + b;
         ALU_CTL_SUB: res = a - b;
         ALU_CTL_SRA: res = $unsigned($signed(a) >>> b[4:0]);
         default:     res = '0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// -----------------------------------------------------------------------------
// alu_mul_iter
//
// Purpose : Iterative shift-add multiplier. It returns the low WIDTH bits of
//           i_mcand * i_mplier. A start pulse loads the operands. The block
//           then performs one add/shift step per cycle for MUL_CYCLES cycles.
//           o_done pulses during the cycle in which the last step executes.
//           During that cycle o_product already carries the final value, so
//           the consumer can register the result on the same edge that
//           retires the last step.
//
// Ports   :
//   i_clk     - clock, rising edge
//   i_rst_n   - asynchronous active-low reset; aborts any multiply in flight
//   i_start   - one-cycle pulse that loads the operands
//   i_mcand   - multiplicand (rs1)
//   i_mplier  - multiplier (rs2)
//   o_done    - high in the cycle of the final iteration
//   o_product - accumulator value after the current iteration
// -----------------------------------------------------------------------------
module alu_mul_iter #(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_mcand,
   input  logic [WIDTH-1:0] i_mplier,
   output logic             o_done,
   output logic [WIDTH-1:0] o_product
);

   localparam int CNT_W = $clog2(MUL_CYCLES);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MUL_CYCLES - 1);

   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;
   logic [WIDTH-1:0] w_acc_next;

   // Accumulator value after this cycle's step. Bits shifted out of r_mcand
   // above WIDTH are dropped, so only the low half of the product is formed.
   assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
   assign o_done     = r_busy && (r_cnt == LAST_ITER);
   assign o_product  = w_acc_next;

   // NOTE: the datapath registers are reset as well as the control registers.
   // An aborted multiply must leave no partial product visible, and the reset
   // state is defined as all-zero.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
      end else if (i_start) begin
         r_acc    <= '0;
         r_mcand  <= i_mcand;
         r_mplier <= i_mplier;
         r_cnt    <= '0;
         r_busy   <= 1'b1;
      end else if (r_busy) begin
         // NOTE: non-blocking assignments here mean every right-hand side sees
         // the pre-edge value. The accumulate, the shifts and the count
         // therefore all belong to the same iteration.
         r_acc    <= w_acc_next;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + 1'b1;
         if (r_cnt == LAST_ITER) begin
            r_busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_exec.sv
// -----------------------------------------------------------------------------
// alu_exec
//
// Purpose : Execution-stage ALU between register read and write-back. A
//           request (control code plus two operands) is accepted on the input
//           valid/ready handshake. The result is returned on the output
//           valid/ready handshake. Single-cycle operations produce a result on
//           the edge that accepts them. MUL runs on the iterative shift-add
//           multiplier (alu_mul_iter) and takes MUL_CYCLES+1 edges.
//
// Configuration:
//   ALU_MUL_FAST_EN - when defined, MUL is computed in one cycle like every
//                     other operation. The BUSY state and alu_mul_iter are not
//                     built.
//
// Ports   :
//   clk_i     - clock, rising edge
//   rst_i     - asynchronous active-low reset
//   valid_i   - request present on ALUCtl_i / data1_i / data2_i
//   ready_o   - request accepted this cycle when valid_i is high
//   ALUCtl_i  - 4-bit ALU control code
//   data1_i   - operand rs1
//   data2_i   - operand rs2 or immediate
//   valid_o   - result valid
//   ready_i   - downstream accepts the result
//   data_o    - result
//   zero_o    - data_o == 0 (meaningful only while valid_o is high)
// -----------------------------------------------------------------------------
module alu_exec
   import alu_exec_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [3:0]       ALUCtl_i,
   input  logic [WIDTH-1:0] data1_i,
   input  logic [WIDTH-1:0] data2_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] data_o,
   output logic             zero_o
);

   alu_state_e       r_state;
   alu_state_e       w_state_next;
   logic [WIDTH-1:0] r_data;
   logic [WIDTH-1:0] w_alu_res;
   logic             w_ready;
   logic             w_accept;
   logic             w_is_mul;
   logic             w_load_alu;

`ifndef ALU_MUL_FAST_EN
   logic             w_mul_start;
   logic             w_mul_done;
   logic             w_load_mul;
   logic [WIDTH-1:0] w_mul_prod;
`endif

   // ---------------------------------------------------------------------
   // Handshake
   // ---------------------------------------------------------------------
   // In DONE, a result that drains this cycle frees the output register.
   // This gives back-to-back throughput, so ready_o depends on ready_i only
   // in DONE. valid_o comes straight from the state register.
   assign w_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && ready_i);
   assign w_accept = valid_i && w_ready;
   assign w_is_mul = (ALUCtl_i == ALU_CTL_MUL);

   assign ready_o  = w_ready;
   assign valid_o  = (r_state == ST_DONE);
   assign data_o   = r_data;
   assign zero_o   = (r_data == '0);

   // ---------------------------------------------------------------------
   // Single-cycle operation mux
   // ---------------------------------------------------------------------
   always_comb begin
      w_alu_res = alu_single_op(ALUCtl_i, data1_i, data2_i);
`ifdef ALU_MUL_FAST_EN
      if (w_is_mul) begin
         w_alu_res = data1_i * data2_i;
      end
`endif
   end

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next state and datapath strobes
   // ---------------------------------------------------------------------
   // NOTE: every signal assigned in this block gets a default first. No path
   // can leave one unassigned, so no latch is inferred.
   always_comb begin
      w_state_next = r_state;
      w_load_alu   = 1'b0;
`ifndef ALU_MUL_FAST_EN
      w_mul_start  = 1'b0;
      w_load_mul   = 1'b0;
`endif
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (w_accept) begin
`ifndef ALU_MUL_FAST_EN
               if (w_is_mul) begin
                  w_mul_start  = 1'b1;
                  w_state_next = ST_BUSY;
               end else begin
                  w_load_alu   = 1'b1;
                  w_state_next = ST_DONE;
               end
`else
               w_load_alu   = 1'b1;
               w_state_next = ST_DONE;
`endif
            end else if ((r_state == ST_DONE) && ready_i) begin
               w_state_next = ST_IDLE;
            end
         end
`ifndef ALU_MUL_FAST_EN
         ST_BUSY: begin
            // The last iteration and the move to DONE share one edge. This
            // gives the MUL_CYCLES+1 latency counted from the accept.
            if (w_mul_done) begin
               w_load_mul   = 1'b1;
               w_state_next = ST_DONE;
            end
         end
`endif
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Result register: written only when a new result is produced. It holds
   // its value throughout DONE, whatever back-pressure arrives.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_data <= '0;
      end else if (w_load_alu) begin
         r_data <= w_alu_res;
`ifndef ALU_MUL_FAST_EN
      end else if (w_load_mul) begin
         r_data <= w_mul_prod;
`endif
      end
   end

`ifndef ALU_MUL_FAST_EN
   // ---------------------------------------------------------------------
   // Iterative multiplier. Operands are captured on the accept edge, so
   // later input changes cannot affect the product.
   // ---------------------------------------------------------------------
   alu_mul_iter #(
      .WIDTH      (WIDTH),
      .MUL_CYCLES (MUL_CYCLES)
   ) u_mul_iter (
      .i_clk     (clk_i),
      .i_rst_n   (rst_i),
      .i_start   (w_mul_start),
      .i_mcand   (data1_i),
      .i_mplier  (data2_i),
      .o_done    (w_mul_done),
      .o_product (w_mul_prod)
   );
`endif

endmodule

// File: tb/tb_alu_exec.sv
// -----------------------------------------------------------------------------
// tb_alu_exec
//
// Self-checking bench for alu_exec. Expected results come from a behavioural
// model built on plain arithmetic. Expected latency is 1 edge for single-cycle
// operations. For MUL it is 33 edges, or 1 edge when ALU_MUL_FAST_EN is
// defined. Outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_alu_exec;

   localparam logic [3:0] C_AND = 4'd0;
   localparam logic [3:0] C_XOR = 4'd1;
   localparam logic [3:0] C_SLL = 4'd2;
   localparam logic [3:0] C_ADD = 4'd3;
   localparam logic [3:0] C_SUB = 4'd4;
   localparam logic [3:0] C_MUL = 4'd5;
   localparam logic [3:0] C_SRA = 4'd6;

`ifdef ALU_MUL_FAST_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        valid_i;
   logic        ready_o;
   logic [3:0]  ALUCtl_i;
   logic [31:0] data1_i;
   logic [31:0] data2_i;
   logic        valid_o;
   logic        ready_i;
   logic [31:0] data_o;
   logic        zero_o;

   int n_vec = 0;
   int n_err = 0;

   alu_exec dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .valid_i  (valid_i),
      .ready_o  (ready_o),
      .ALUCtl_i (ALUCtl_i),
      .data1_i  (data1_i),
      .data2_i  (data2_i),
      .valid_o  (valid_o),
      .ready_i  (ready_i),
      .data_o   (data_o),
      .zero_o   (zero_o)
   );

   always #5 clk_i = ~clk_i;

   // Behavioural reference: results straight from the operation definitions.
   function automatic logic [31:0] ref_alu(input logic [3:0] ctl,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      int unsigned sh;
      logic [63:0] prod;
      logic [31:0] fill;
      sh = b % 32;
      case (ctl)
         C_AND: return a & b;
         C_XOR: return a ^ b;
         C_ADD: return a + b;
         C_SUB: return a - b;
         C_SLL: return a << sh;
         C_MUL: begin
            prod = {32'd0, a} * {32'd0, b};
            return prod[31:0];
         end
         C_SRA: begin
            // Negative values shift in ones from the top.
            fill = (a[31] && sh != 0) ? ~(32'hFFFF_FFFF >> sh) : 32'd0;
            return (a >> sh) | fill;
         end
         default: return 32'd0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one request with ready_i high. Measure the latency to valid_o and
   // check the result. Garbage is driven on the inputs right after the accept.
   task automatic run_op(input string tag, input logic [3:0] ctl,
                         input logic [31:0] a, input logic [31:0] b);
      int          lat;
      int          exp_lat;
      logic [31:0] exp;
      exp     = ref_alu(ctl, a, b);
      exp_lat = (ctl == C_MUL) ? MUL_LAT : 1;
      ready_i = 1'b1;
      check({tag, ".ready_o"}, 32'(ready_o), 32'd1);
      ALUCtl_i = ctl;
      data1_i  = a;
      data2_i  = b;
      valid_i  = 1'b1;
      @(posedge clk_i); #1;
      valid_i  = 1'b0;
      ALUCtl_i = 4'($urandom);
      data1_i  = $urandom;
      data2_i  = $urandom;
      lat = 1;
      while (valid_o !== 1'b1 && lat < 100) begin
         @(posedge clk_i); #1;
         lat++;
      end
      check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
      check({tag, ".data_o"}, data_o, exp);
      check({tag, ".zero_o"}, 32'(zero_o), 32'(exp == 32'd0));
   endtask

   initial begin
      logic [3:0]  ctl;
      logic [31:0] a;
      logic [31:0] b;
      int          r;

      rst_i    = 1'b0;
      valid_i  = 1'b0;
      ready_i  = 1'b0;
      ALUCtl_i = 4'd0;
      data1_i  = 32'd0;
      data2_i  = 32'd0;

      // Reset state
      repeat (3) @(posedge clk_i);
      #1;
      check("rst.ready_o", 32'(ready_o), 32'd1);
      check("rst.valid_o", 32'(valid_o), 32'd0);
      check("rst.data_o",  data_o,       32'd0);
      check("rst.zero_o",  32'(zero_o),  32'd1);
      @(negedge clk_i);
      rst_i = 1'b1;
      @(posedge clk_i); #1;

      // Directed vectors from the operation rules
      run_op("add_wrap",  C_ADD, 32'hFFFF_FFFF, 32'h1);
      run_op("sra_neg",   C_SRA, 32'h8000_0000, 32'd4);
      run_op("sll_mask",  C_SLL, 32'h1,         32'h21);
      run_op("mul_neg",   C_MUL, 32'd7,         32'hFFFF_FFFD);
      run_op("mul_b2b",   C_MUL, 32'h1234_5678, 32'h9ABC_DEF1);
      run_op("undef_f",   4'hF,  32'h1234,      32'h5);
      run_op("and",       C_AND, 32'hF0F0_A5A5, 32'h0FF0_FFFF);
      run_op("sra_pos31", C_SRA, 32'h7FFF_FFFF, 32'd31);

      // Drain to IDLE
      @(posedge clk_i); #1;
      check("drain.valid_o", 32'(valid_o), 32'd0);

      // Back-pressure: SUB held 4 cycles, then drain + XOR accept together
      ready_i  = 1'b0;
      ALUCtl_i = C_SUB;
      data1_i  = 32'd5;
      data2_i  = 32'd3;
      valid_i  = 1'b1;
      @(posedge clk_i); #1;
      valid_i  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("bp.valid_o", 32'(valid_o), 32'd1);
         check("bp.data_o",  data_o,       32'd2);
         check("bp.ready_o", 32'(ready_o), 32'd0);
         @(posedge clk_i); #1;
      end
      ALUCtl_i = C_XOR;
      data1_i  = 32'hDEAD_BEEF;
      data2_i  = 32'h0F0F_0F0F;
      valid_i  = 1'b1;
      ready_i  = 1'b1;
      #1;
      check("bp.ready_o_rise", 32'(ready_o), 32'd1);
      @(posedge clk_i); #1;
      valid_i  = 1'b0;
      check("bp.xor.valid_o", 32'(valid_o), 32'd1);
      check("bp.xor.data_o",  data_o, ref_alu(C_XOR, 32'hDEAD_BEEF, 32'h0F0F_0F0F));
      @(posedge clk_i); #1;
      check("bp.idle.valid_o", 32'(valid_o), 32'd0);

      // Reset in the middle of a MUL
      ALUCtl_i = C_MUL;
      data1_i  = 32'hFFFF_FFFF;
      data2_i  = 32'hFFFF_FFFF;
      valid_i  = 1'b1;
      @(posedge clk_i); #1;
      valid_i  = 1'b0;
      repeat (10) @(posedge clk_i);
      #2;
      check("midrst.pre.ready_o", 32'(ready_o), (MUL_LAT == 1) ? 32'd1 : 32'd0);
      rst_i = 1'b0;
      #1;
      check("midrst.ready_o", 32'(ready_o), 32'd1);
      check("midrst.valid_o", 32'(valid_o), 32'd0);
      check("midrst.data_o",  data_o,       32'd0);
      check("midrst.zero_o",  32'(zero_o),  32'd1);
      @(negedge clk_i);
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      run_op("post_rst_add", C_ADD, 32'd1, 32'd1);

      // Randomized operations against the reference model
      for (int k = 0; k < 40; k++) begin
         r   = $urandom_range(0, 8);
         ctl = (r == 8) ? 4'd12 : 4'(r);
         a   = $urandom;
         b   = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
         run_op("rand", ctl, a, b);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
